// File: rtl/ram_tdp.sv
// True dual-port, byte-writable synchronous RAM. Each port has its own write mode
// and a valid-qualified read pipeline. Pipeline registers are reset; the array is not.

module ram_tdp #(
  parameter int    MEM_DEPTH    = 64,
  parameter int    BYTE_WIDTH   = 8,
  parameter int    BYTE_NUM     = 4,
  parameter int    READ_LATENCY = 2,
  parameter string WRITE_MODE_A = "READ_FIRST",
  parameter string WRITE_MODE_B = "READ_FIRST",
  parameter string MEM_FILE     = "",
  parameter int    ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int    MEM_WIDTH    = BYTE_WIDTH * BYTE_NUM
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  a_en_i,
  input  logic [BYTE_NUM-1:0]   a_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [MEM_WIDTH-1:0]  a_data_i,
  output logic [MEM_WIDTH-1:0]  a_data_o,
  output logic                  a_valid_o,
  input  logic                  b_en_i,
  input  logic [BYTE_NUM-1:0]   b_wr_en_i,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [MEM_WIDTH-1:0]  b_data_i,
  output logic [MEM_WIDTH-1:0]  b_data_o,
  output logic                  b_valid_o
);

  typedef enum logic [1:0] {
    WM_READ_FIRST,
    WM_WRITE_FIRST,
    WM_NO_CHANGE
  } wmode_e;

  localparam wmode_e MODE_A = (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
                              (WRITE_MODE_A == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_READ_FIRST;
  localparam wmode_e MODE_B = (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
                              (WRITE_MODE_B == "NO_CHANGE")   ? WM_NO_CHANGE   : WM_READ_FIRST;

  function automatic logic [MEM_WIDTH-1:0] merge_bytes(
    input logic [MEM_WIDTH-1:0] old_word,
    input logic [MEM_WIDTH-1:0] new_word,
    input logic [BYTE_NUM-1:0]  byte_en
  );
    logic [MEM_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (byte_en[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic                  en       [2];
  logic [BYTE_NUM-1:0]   we       [2];
  logic [ADDR_WIDTH-1:0] addr     [2];
  logic [MEM_WIDTH-1:0]  wdata    [2];
  logic                  in_range [2];
  logic                  rd_valid [2];
  logic [MEM_WIDTH-1:0]  rd_data  [2];

  assign en[0]    = a_en_i;
  assign en[1]    = b_en_i;
  assign we[0]    = a_wr_en_i;
  assign we[1]    = b_wr_en_i;
  assign addr[0]  = a_addr_i;
  assign addr[1]  = b_addr_i;
  assign wdata[0] = a_data_i;
  assign wdata[1] = b_data_i;

  assign a_valid_o = rd_valid[0];
  assign a_data_o  = rd_data[0];
  assign b_valid_o = rd_valid[1];
  assign b_data_o  = rd_data[1];

  // NOTE: the array has no reset branch; clearing a RAM costs a write per word and
  // prevents block-RAM mapping, so contents persist across reset.
  always_ff @(posedge clk_i) begin
    // Port B is applied first so port A's assignment lands last and wins on a shared byte.
    for (int p = 1; p >= 0; p--) begin
      if (en[p] && in_range[p]) begin
        for (int i = 0; i < BYTE_NUM; i++) begin
          if (we[p][i]) mem[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[p][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam wmode_e MODE = (p == 0) ? MODE_A : MODE_B;

    logic [MEM_WIDTH-1:0]    old_word;
    logic [MEM_WIDTH-1:0]    rd_word;
    logic                    issue;
    logic [READ_LATENCY-1:0] vld_q;
    logic [MEM_WIDTH-1:0]    dat_q [READ_LATENCY];

    assign in_range[p] = ({1'b0, addr[p]} < (ADDR_WIDTH+1)'(MEM_DEPTH));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      old_word = '0;
      rd_word  = '0;
      issue    = 1'b0;
      if (in_range[p]) begin
        old_word = mem[addr[p]];
        rd_word  = (MODE == WM_WRITE_FIRST) ? merge_bytes(old_word, wdata[p], we[p]) : old_word;
      end
      issue = en[p] && !((MODE == WM_NO_CHANGE) && (|we[p]));
    end

    // Stage 0 is the array read register; later stages load only behind a valid.
    // NOTE: non-blocking assignments let each stage sample its neighbour's pre-edge value.
    always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
        vld_q <= '0;
        for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
        vld_q[0] <= issue;
        if (issue) dat_q[0] <= rd_word;
        for (int i = 1; i < READ_LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
        end
      end
    end

    assign rd_valid[p] = vld_q[READ_LATENCY-1];
    assign rd_data[p]  = dat_q[READ_LATENCY-1];
  end

endmodule

// File: tb/tb_ram_tdp.sv
// Bench for ram_tdp: two instances with different depth, latency and write modes,
// driven by shared stimulus and checked against a queue-based reference model.

module tb_ram_tdp;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b1;
  logic        a_en_i, b_en_i;
  logic [3:0]  a_wr_en_i, b_wr_en_i;
  logic [5:0]  a_addr_i, b_addr_i;
  logic [31:0] a_data_i, b_data_i;

  logic [31:0] a_data_o0, b_data_o0, a_data_o1, b_data_o1;
  logic        a_valid_o0, b_valid_o0, a_valid_o1, b_valid_o1;

  always #5 clk_i = ~clk_i;

  ram_tdp #(.MEM_DEPTH(64), .READ_LATENCY(2),
            .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST")) u0 (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .a_en_i(a_en_i), .a_wr_en_i(a_wr_en_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .a_data_o(a_data_o0), .a_valid_o(a_valid_o0),
    .b_en_i(b_en_i), .b_wr_en_i(b_wr_en_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .b_data_o(b_data_o0), .b_valid_o(b_valid_o0));

  ram_tdp #(.MEM_DEPTH(48), .READ_LATENCY(4),
            .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST")) u1 (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .a_en_i(a_en_i), .a_wr_en_i(a_wr_en_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .a_data_o(a_data_o1), .a_valid_o(a_valid_o1),
    .b_en_i(b_en_i), .b_wr_en_i(b_wr_en_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .b_data_o(b_data_o1), .b_valid_o(b_valid_o1));

  // Per-instance configuration; mode 0 = read-first, 1 = write-first, 2 = no-change.
  localparam int RLAT  [2]    = '{2, 4};
  localparam int DEPTH [2]    = '{64, 48};
  localparam int MODE  [2][2] = '{'{0, 1}, '{2, 0}};

  logic [31:0] dq [2][2];
  logic        vq [2][2];
  always_comb begin
    dq[0][0] = a_data_o0;  dq[0][1] = b_data_o0;
    dq[1][0] = a_data_o1;  dq[1][1] = b_data_o1;
    vq[0][0] = a_valid_o0; vq[0][1] = b_valid_o0;
    vq[1][0] = a_valid_o1; vq[1][1] = b_valid_o1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h", name, got, exp);
    end
  endtask

  // Reference model: word arrays plus a queue of reads with the edge they become visible.
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } rd_t;

  rd_t         pend   [2][2][$];
  logic [31:0] m_mem  [2][64];
  bit          m_known[2][64];
  logic [31:0] last_d [2][2];
  bit          last_k [2][2];
  int          edge_n = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        pend[d][p].delete();
        last_d[d][p] = 32'h0;
        last_k[d][p] = 1'b1;
      end
    end
  endtask

  task automatic model_edge();
    logic        en  [2];
    logic [3:0]  we  [2];
    int          ad  [2];
    logic [31:0] din [2];
    en[0] = a_en_i;     en[1] = b_en_i;
    we[0] = a_wr_en_i;  we[1] = b_wr_en_i;
    ad[0] = int'(a_addr_i); ad[1] = int'(b_addr_i);
    din[0] = a_data_i;  din[1] = b_data_i;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rd_t         r;
        logic [31:0] v;
        bit          k;
        if (!en[p]) continue;
        if (MODE[d][p] == 2 && we[p] != 4'h0) continue;
        if (ad[p] >= DEPTH[d]) begin
          v = 32'h0;
          k = 1'b1;
        end else begin
          v = m_mem[d][ad[p]];
          k = m_known[d][ad[p]];
          if (MODE[d][p] == 1) begin
            for (int b = 0; b < 4; b++) if (we[p][b]) v[8*b +: 8] = din[p][8*b +: 8];
            if (we[p] == 4'hF) k = 1'b1;
          end
        end
        r.due = edge_n + RLAT[d] - 1;
        r.data = v;
        r.known = k;
        pend[d][p].push_back(r);
      end
      // Port A is applied after port B so that A's bytes win.
      for (int p = 1; p >= 0; p--) begin
        if (en[p] && ad[p] < DEPTH[d]) begin
          for (int b = 0; b < 4; b++) if (we[p][b]) m_mem[d][ad[p]][8*b +: 8] = din[p][8*b +: 8];
          if (we[p] == 4'hF) m_known[d][ad[p]] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        rd_t  r;
        logic exp_v;
        string pn;
        pn = (p == 0) ? "a" : "b";
        exp_v = 1'b0;
        if (pend[d][p].size() != 0 && pend[d][p][0].due == edge_n) begin
          r = pend[d][p].pop_front();
          exp_v = 1'b1;
          last_d[d][p] = r.data;
          last_k[d][p] = r.known;
        end
        check($sformatf("u%0d_%s_valid@%0d", d, pn, edge_n), {31'b0, vq[d][p]}, {31'b0, exp_v});
        if (last_k[d][p]) check($sformatf("u%0d_%s_data@%0d", d, pn, edge_n), dq[d][p], last_d[d][p]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    edge_n++;
    if (!arstn_i) model_reset();
    else model_edge();
    #1 compare_all();
  endtask

  task automatic drive(input logic ae, input logic [3:0] awe, input logic [5:0] aa, input logic [31:0] ad,
                       input logic be, input logic [3:0] bwe, input logic [5:0] ba, input logic [31:0] bd);
    a_en_i = ae; a_wr_en_i = awe; a_addr_i = aa; a_data_i = ad;
    b_en_i = be; b_wr_en_i = bwe; b_addr_i = ba; b_data_i = bd;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 4'h0, 6'd0, 32'h0);
  endtask

  typedef struct {
    logic a_en; logic [3:0] a_we; logic [5:0] a_addr; logic [31:0] a_din;
    logic b_en; logic [3:0] b_we; logic [5:0] b_addr; logic [31:0] b_din;
    logic e0_av; logic [31:0] e0_ad; logic e0_bv; logic [31:0] e0_bd;
    logic e1_av; logic [31:0] e1_ad;
  } vec_t;

  vec_t vt [15];

  initial begin
    // Directed vectors; expectations assume word i holds i after initialisation.
    // u0: A read-first / B write-first, latency 2. u1 port A: no-change, latency 4, depth 48.
    vt[0]  = '{1'b1, 4'h0, 6'd5,  32'h0,        1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h5,        1'b0, 32'h0,        1'b1, 32'h5};
    vt[1]  = '{1'b1, 4'hF, 6'd3,  32'h11223344, 1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h3,        1'b0, 32'h0,        1'b0, 32'h5};
    vt[2]  = '{1'b1, 4'h5, 6'd3,  32'hAABBCCDD, 1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h11223344, 1'b0, 32'h0,        1'b0, 32'h5};
    vt[3]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 4'h0, 6'd3, 32'h0,        1'b0, 32'h11223344, 1'b1, 32'h11BB33DD, 1'b0, 32'h5};
    vt[4]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 4'hF, 6'd3, 32'h11223344, 1'b0, 32'h11223344, 1'b1, 32'h11223344, 1'b0, 32'h5};
    vt[5]  = '{1'b1, 4'hF, 6'd3,  32'hDEADBEEF, 1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h11223344, 1'b0, 32'h11223344, 1'b0, 32'h5};
    vt[6]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 4'hF, 6'd3, 32'h11223344, 1'b0, 32'h11223344, 1'b1, 32'h11223344, 1'b0, 32'h5};
    vt[7]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 4'hF, 6'd3, 32'hDEADBEEF, 1'b0, 32'h11223344, 1'b1, 32'hDEADBEEF, 1'b0, 32'h5};
    vt[8]  = '{1'b1, 4'hF, 6'd7,  32'hCAFEF00D, 1'b1, 4'h0, 6'd7, 32'h0,        1'b1, 32'h7,        1'b1, 32'h7,        1'b0, 32'h5};
    vt[9]  = '{1'b0, 4'h0, 6'd0,  32'h0,        1'b1, 4'h0, 6'd7, 32'h0,        1'b0, 32'h7,        1'b1, 32'hCAFEF00D, 1'b0, 32'h5};
    vt[10] = '{1'b1, 4'hF, 6'd9,  32'h1,        1'b1, 4'hF, 6'd9, 32'h2,        1'b1, 32'h9,        1'b1, 32'h2,        1'b0, 32'h5};
    vt[11] = '{1'b1, 4'h0, 6'd9,  32'h0,        1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h1,        1'b0, 32'h2,        1'b1, 32'h1};
    vt[12] = '{1'b1, 4'h0, 6'd50, 32'h0,        1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h32,       1'b0, 32'h2,        1'b1, 32'h0};
    vt[13] = '{1'b1, 4'hF, 6'd50, 32'hFFFFFFFF, 1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'h32,       1'b0, 32'h2,        1'b0, 32'h0};
    vt[14] = '{1'b1, 4'h0, 6'd50, 32'h0,        1'b0, 4'h0, 6'd0, 32'h0,        1'b1, 32'hFFFFFFFF, 1'b0, 32'h2,        1'b1, 32'h0};

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++) begin
        m_mem[d][i] = 32'h0;
        m_known[d][i] = 1'b0;
      end
    model_reset();
    idle();

    // Reset held with enables toggling: outputs must stay zero.
    #1 arstn_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 4'h0, 6'(i), 32'h0, ~i[0], 4'h0, 6'(i + 1), 32'h0);
      step();
    end
    idle();
    arstn_i = 1'b1;

    // Fill both arrays with word i = i through port A.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 4'hF, 6'(i), 32'(i), 1'b0, 4'h0, 6'd0, 32'h0);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) step();
    arstn_i = 1'b0;
    step();
    arstn_i = 1'b1;
    step();

    for (int v = 0; v < 15; v++) begin
      drive(vt[v].a_en, vt[v].a_we, vt[v].a_addr, vt[v].a_din, vt[v].b_en, vt[v].b_we, vt[v].b_addr, vt[v].b_din);
      step();
      idle();
      step();
      check($sformatf("vec%0d_u0_a_valid", v), {31'b0, a_valid_o0}, {31'b0, vt[v].e0_av});
      check($sformatf("vec%0d_u0_a_data", v), a_data_o0, vt[v].e0_ad);
      check($sformatf("vec%0d_u0_b_valid", v), {31'b0, b_valid_o0}, {31'b0, vt[v].e0_bv});
      check($sformatf("vec%0d_u0_b_data", v), b_data_o0, vt[v].e0_bd);
      step();
      step();
      check($sformatf("vec%0d_u1_a_valid", v), {31'b0, a_valid_o1}, {31'b0, vt[v].e1_av});
      check($sformatf("vec%0d_u1_a_data", v), a_data_o1, vt[v].e1_ad);
    end

    // Streaming: 16 back-to-back reads on port B; the latency-4 instance must answer in order.
    for (int c = 0; c < 24; c++) begin
      if (c < 16) drive(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 4'h0, 6'(c), 32'h0);
      else idle();
      step();
      if (c == 2) check("stream_pre_valid", {31'b0, b_valid_o1}, 32'h0);
      if (c >= 3 && c < 19) begin
        check($sformatf("stream_valid_%0d", c - 3), {31'b0, b_valid_o1}, 32'h1);
        check($sformatf("stream_data_%0d", c - 3), b_data_o1, m_mem[1][c - 3]);
      end
      if (c >= 19) begin
        check($sformatf("stream_tail_valid_%0d", c), {31'b0, b_valid_o1}, 32'h0);
        check($sformatf("stream_tail_data_%0d", c), b_data_o1, m_mem[1][15]);
      end
    end

    // Randomised traffic with frequent same-address collisions.
    for (int i = 0; i < 400; i++) begin
      a_en_i    = ($urandom_range(0, 3) != 0);
      a_wr_en_i = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      a_addr_i  = 6'($urandom);
      a_data_i  = $urandom;
      b_en_i    = ($urandom_range(0, 3) != 0);
      b_wr_en_i = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      b_addr_i  = ($urandom_range(0, 3) == 0) ? a_addr_i : 6'($urandom);
      b_data_i  = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < 6; i++) step();

    // Reset while reads are in flight: outputs clear at once, nothing stale afterwards.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h0, 6'(i + 1), 32'h0, 1'b1, 4'h0, 6'(i + 4), 32'h0);
      step();
    end
    idle();
    step();
    #1 arstn_i = 1'b0;
    model_reset();
    #1;
    check("midrst_u0_a_valid", {31'b0, a_valid_o0}, 32'h0);
    check("midrst_u0_b_valid", {31'b0, b_valid_o0}, 32'h0);
    check("midrst_u1_a_valid", {31'b0, a_valid_o1}, 32'h0);
    check("midrst_u1_b_valid", {31'b0, b_valid_o1}, 32'h0);
    check("midrst_u0_a_data", a_data_o0, 32'h0);
    check("midrst_u0_b_data", b_data_o0, 32'h0);
    check("midrst_u1_a_data", a_data_o1, 32'h0);
    check("midrst_u1_b_data", b_data_o1, 32'h0);
    step();
    step();
    arstn_i = 1'b1;
    for (int i = 0; i < 8; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
